// File: rtl/async_fifo_wr_ctrl.sv
// async_fifo_wr_ctrl: write-domain pointer, Gray export and full/level tracking for a dual-clock FIFO
module async_fifo_wr_ctrl #(
  parameter int ADDR_WIDTH  = 4,
  parameter int AFULL_LEVEL = 2**ADDR_WIDTH - 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH:0]   rptr_gray_i,
  output logic                  wr_ce_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [ADDR_WIDTH:0]   wptr_gray_o,
  output logic                  full_o,
  output logic                  afull_o,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  overflow_o
);
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 2**ADDR_WIDTH;
  logic [PW-1:0] wptr_bin, wptr_next, rptr_bin, lvl;
  for (genvar i = 0; i < PW; i++) begin : g_g2b
    assign rptr_bin[i] = ^(rptr_gray_i >> i);
  end
  always_comb begin
    wr_ce_o   = wr_en_i & ~full_o & ~rst_i;
    wr_addr_o = wptr_bin[ADDR_WIDTH-1:0];
    wptr_next = wptr_bin + {{ADDR_WIDTH{1'b0}}, wr_ce_o};
    lvl       = wptr_next - rptr_bin;
  end
  // lvl above DEPTH only arises from a corrupt read pointer; >= keeps writes blocked then
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_bin    <= '0;
      wptr_gray_o <= '0;
      full_o      <= 1'b0;
      afull_o     <= 1'b0;
      level_o     <= '0;
      overflow_o  <= 1'b0;
    end else begin
      wptr_bin    <= wptr_next;
      wptr_gray_o <= wptr_next ^ (wptr_next >> 1);
      level_o     <= lvl;
      full_o      <= lvl >= PW'(DEPTH);
      afull_o     <= lvl >= PW'(AFULL_LEVEL);
      overflow_o  <= overflow_o | (wr_en_i & full_o);
    end
  end
endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// tb_async_fifo_wr_ctrl: directed vector table plus hand-written reset and wrap sequences
module tb_async_fifo_wr_ctrl;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0;
  logic [2:0] rg = '0;
  logic ce, full, afull, ovf;
  logic [1:0] addr;
  logic [2:0] gray, lvl;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  async_fifo_wr_ctrl #(.ADDR_WIDTH(2), .AFULL_LEVEL(3)) dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(en), .rptr_gray_i(rg),
    .wr_ce_o(ce), .wr_addr_o(addr), .wptr_gray_o(gray),
    .full_o(full), .afull_o(afull), .level_o(lvl), .overflow_o(ovf)
  );

  typedef struct {
    logic rst, en;
    logic [2:0] rg;
    logic ce;
    logic [1:0] addr;
    logic [2:0] gray;
    logic full, afull;
    logic [2:0] lvl;
    logic ovf;
  } vec_t;

  vec_t tbl[26];

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  function automatic logic [2:0] g(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  initial begin
    //          rst en  rg      ce addr   gray    full af lvl   ovf
    tbl[0]  = '{1, 1, 3'b000, 0, 2'd0, 3'b000, 0, 0, 3'd0, 0};
    tbl[1]  = '{0, 1, 3'b000, 1, 2'd0, 3'b001, 0, 0, 3'd1, 0};
    tbl[2]  = '{0, 1, 3'b000, 1, 2'd1, 3'b011, 0, 0, 3'd2, 0};
    tbl[3]  = '{0, 1, 3'b000, 1, 2'd2, 3'b010, 0, 1, 3'd3, 0};
    tbl[4]  = '{0, 1, 3'b000, 1, 2'd3, 3'b110, 1, 1, 3'd4, 0};
    tbl[5]  = '{0, 1, 3'b000, 0, 2'd0, 3'b110, 1, 1, 3'd4, 1};
    tbl[6]  = '{0, 1, 3'b000, 0, 2'd0, 3'b110, 1, 1, 3'd4, 1};
    tbl[7]  = '{0, 0, 3'b000, 0, 2'd0, 3'b110, 1, 1, 3'd4, 1};
    tbl[8]  = '{0, 0, 3'b001, 0, 2'd0, 3'b110, 0, 1, 3'd3, 1};
    tbl[9]  = '{0, 1, 3'b001, 1, 2'd0, 3'b111, 1, 1, 3'd4, 1};
    tbl[10] = '{1, 0, 3'b000, 0, 2'd1, 3'b000, 0, 0, 3'd0, 0};
    tbl[11] = '{0, 0, 3'b111, 0, 2'd0, 3'b000, 0, 1, 3'd3, 0};
    tbl[12] = '{0, 1, 3'b101, 1, 2'd0, 3'b001, 0, 1, 3'd3, 0};
    tbl[13] = '{0, 1, 3'b100, 1, 2'd1, 3'b011, 0, 1, 3'd3, 0};
    tbl[14] = '{0, 1, 3'b000, 1, 2'd2, 3'b010, 0, 1, 3'd3, 0};
    tbl[15] = '{0, 1, 3'b001, 1, 2'd3, 3'b110, 0, 1, 3'd3, 0};
    tbl[16] = '{0, 1, 3'b011, 1, 2'd0, 3'b111, 0, 1, 3'd3, 0};
    tbl[17] = '{0, 1, 3'b010, 1, 2'd1, 3'b101, 0, 1, 3'd3, 0};
    tbl[18] = '{0, 1, 3'b110, 1, 2'd2, 3'b100, 0, 1, 3'd3, 0};
    tbl[19] = '{0, 1, 3'b111, 1, 2'd3, 3'b000, 0, 1, 3'd3, 0};
    tbl[20] = '{0, 0, 3'b110, 0, 2'd0, 3'b000, 1, 1, 3'd4, 0};
    tbl[21] = '{0, 1, 3'b110, 0, 2'd0, 3'b000, 1, 1, 3'd4, 1};
    tbl[22] = '{0, 1, 3'b010, 0, 2'd0, 3'b000, 1, 1, 3'd5, 1};
    tbl[23] = '{0, 0, 3'b000, 0, 2'd0, 3'b000, 0, 0, 3'd0, 1};
    tbl[24] = '{1, 1, 3'b000, 0, 2'd0, 3'b000, 0, 0, 3'd0, 0};
    tbl[25] = '{0, 1, 3'b000, 1, 2'd0, 3'b001, 0, 0, 3'd1, 0};

    @(negedge clk);
    rst = 1'b1; en = 1'b1; rg = '0;
    #1 chk("rst_ce", -1, int'(ce), 0);

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; en = tbl[i].en; rg = tbl[i].rg;
      #1;
      chk("wr_ce", i, int'(ce), int'(tbl[i].ce));
      chk("wr_addr", i, int'(addr), int'(tbl[i].addr));
      @(posedge clk);
      #1;
      chk("wptr_gray", i, int'(gray), int'(tbl[i].gray));
      chk("full", i, int'(full), int'(tbl[i].full));
      chk("afull", i, int'(afull), int'(tbl[i].afull));
      chk("level", i, int'(lvl), int'(tbl[i].lvl));
      chk("overflow", i, int'(ovf), int'(tbl[i].ovf));
    end

    begin
      logic [2:0] eb, prev;
      eb = 3'd1;
      prev = gray;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        rst = 1'b0; en = 1'b1; rg = g(eb + 3'd1 - 3'd2);
        #1 chk("trk_ce", 100 + k, int'(ce), 1);
        @(posedge clk);
        #1;
        eb = eb + 3'd1;
        chk("trk_gray", 100 + k, int'(gray), int'(g(eb)));
        chk("trk_1bit", 100 + k, $countones(gray ^ prev), 1);
        chk("trk_level", 100 + k, int'(lvl), 2);
        chk("trk_full", 100 + k, int'(full), 0);
        prev = gray;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
